// File: rtl/rvc_fetch_decoder.sv
// Realigns a 32-bit fetch stream into 16/32-bit instructions and expands RVC to RV32I.
// Output is two cycles after fetch acceptance; out_* is held while !out_ready and in_ready drops when the buffer fills.
module rvc_fetch_decoder #(
  parameter bit EN_RVC = 1'b1,
  parameter int BUF_HW = 4,
  parameter int PC_W   = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_data,
  input  logic [PC_W-1:0] in_pc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [31:0]     out_inst,
  output logic [PC_W-1:0] out_pc,
  output logic            out_is_c,
  output logic            out_illegal,
  output logic [31:0]     out_imm,
  output logic [4:0]      out_rs1,
  output logic [4:0]      out_rs2,
  output logic [4:0]      out_rd
);
  localparam int CW = $clog2(BUF_HW + 1);

  logic [15:0]     hb   [BUF_HW];
  logic [15:0]     hb_n [BUF_HW];
  logic [15:0]     hx   [BUF_HW+2];
  logic [CW-1:0]   cnt, cnt_n, base;
  logic [PC_W-1:0] buf_pc, buf_pc_n;
  logic            in_fire, head_c, head_w, load;
  logic [1:0]      cons;

  assign in_ready = !rst && !flush && (cnt <= CW'(BUF_HW - 2));
  assign in_fire  = in_valid && in_ready;
  assign head_c   = (cnt != '0) && (hb[0][1:0] != 2'b11);
  assign head_w   = (cnt >= CW'(2)) && (hb[0][1:0] == 2'b11);
  assign load     = (head_c || head_w) && (!out_valid || out_ready);
  assign cons     = !load ? 2'd0 : (head_c ? 2'd1 : 2'd2);
  assign base     = cnt - CW'(cons);

  // Shift out consumed halfwords, then append the new word behind what remains.
  always_comb begin
    for (int i = 0; i < BUF_HW; i++) hx[i] = hb[i];
    hx[BUF_HW]   = 16'h0000;
    hx[BUF_HW+1] = 16'h0000;
    for (int i = 0; i < BUF_HW; i++) begin
      case (cons)
        2'd1:    hb_n[i] = hx[i+1];
        2'd2:    hb_n[i] = hx[i+2];
        default: hb_n[i] = hb[i];
      endcase
      if (in_fire && CW'(i) == base)
        hb_n[i] = in_pc[1] ? in_data[31:16] : in_data[15:0];
      if (in_fire && !in_pc[1] && CW'(i) == base + CW'(1))
        hb_n[i] = in_data[31:16];
    end
    cnt_n = base;
    if (in_fire) cnt_n = base + (in_pc[1] ? CW'(1) : CW'(2));
    buf_pc_n = (in_fire && base == '0) ? in_pc : buf_pc + (PC_W'(cons) << 1);
  end

  logic [15:0] c;
  logic [4:0]  rd, rs2, rdp, rs1p, rs2p;
  logic [11:0] imm6;
  logic [6:0]  uimm;
  logic [20:0] joff;
  logic [12:0] boff;
  logic [31:0] x_inst, sel_inst;
  logic        x_ill;

  assign c    = hb[0];
  assign rd   = c[11:7];
  assign rs2  = c[6:2];
  assign rdp  = {2'b01, c[4:2]};
  assign rs1p = {2'b01, c[9:7]};
  assign rs2p = {2'b01, c[4:2]};
  assign imm6 = {{6{c[12]}}, c[12], c[6:2]};
  assign uimm = {c[5], c[12:10], c[6], 2'b00};
  assign joff = {{9{c[12]}}, c[12], c[8], c[10:9], c[6], c[7], c[2], c[11], c[5:3], 1'b0};
  assign boff = {{4{c[12]}}, c[12], c[6:5], c[2], c[11:10], c[4:3], 1'b0};

  always_comb begin
    x_inst = 32'h0;
    x_ill  = 1'b0;
    case (c[1:0])
      2'b00: case (c[15:13])
        3'b010:  x_inst = {5'b0, uimm, rs1p, 3'b010, rdp, 7'b0000011};
        3'b110:  x_inst = {5'b0, uimm[6:5], rs2p, rs1p, 3'b010, uimm[4:0], 7'b0100011};
        default: x_ill = 1'b1;
      endcase
      2'b01: case (c[15:13])
        3'b000:  x_inst = {imm6, rd, 3'b000, rd, 7'b0010011};
        3'b010:  x_inst = {imm6, 5'd0, 3'b000, rd, 7'b0010011};
        3'b001, 3'b101:
          x_inst = {joff[20], joff[10:1], joff[11], joff[19:12], (c[15] ? 5'd0 : 5'd1), 7'b1101111};
        3'b100: case (c[11:10])
          2'b00: begin x_ill = c[12]; x_inst = {7'b0000000, c[6:2], rs1p, 3'b101, rs1p, 7'b0010011}; end
          2'b01: begin x_ill = c[12]; x_inst = {7'b0100000, c[6:2], rs1p, 3'b101, rs1p, 7'b0010011}; end
          2'b10: x_inst = {imm6, rs1p, 3'b111, rs1p, 7'b0010011};
          default: begin
            x_ill = c[12];
            case (c[6:5])
              2'b00:   x_inst = {7'b0100000, rs2p, rs1p, 3'b000, rs1p, 7'b0110011};
              2'b01:   x_inst = {7'b0000000, rs2p, rs1p, 3'b100, rs1p, 7'b0110011};
              2'b10:   x_inst = {7'b0000000, rs2p, rs1p, 3'b110, rs1p, 7'b0110011};
              default: x_inst = {7'b0000000, rs2p, rs1p, 3'b111, rs1p, 7'b0110011};
            endcase
          end
        endcase
        3'b110, 3'b111:
          x_inst = {boff[12], boff[10:5], 5'd0, rs1p, 2'b00, c[13], boff[4:1], boff[11], 7'b1100011};
        default: x_ill = 1'b1;
      endcase
      2'b10: case (c[15:13])
        3'b000: begin x_ill = c[12]; x_inst = {7'b0, c[6:2], rd, 3'b001, rd, 7'b0010011}; end
        3'b100: begin
          if (rs2 == 5'd0) begin
            x_ill  = (rd == 5'd0);
            x_inst = {12'b0, rd, 3'b000, (c[12] ? 5'd1 : 5'd0), 7'b1100111};
          end else begin
            x_inst = {7'b0, rs2, (c[12] ? rd : 5'd0), 3'b000, rd, 7'b0110011};
          end
        end
        default: x_ill = 1'b1;
      endcase
      default: x_ill = 1'b1;
    endcase
    if (!EN_RVC) x_ill = 1'b1;
  end

  assign sel_inst = head_c ? (x_ill ? 32'h0 : x_inst) : {hb[1], hb[0]};

  always_ff @(posedge clk) begin
    hb <= hb_n;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt         <= '0;
      buf_pc      <= '0;
      out_valid   <= 1'b0;
      out_inst    <= 32'h0;
      out_pc      <= '0;
      out_is_c    <= 1'b0;
      out_illegal <= 1'b0;
    end else if (flush) begin
      cnt       <= '0;
      out_valid <= 1'b0;
    end else begin
      cnt    <= cnt_n;
      buf_pc <= buf_pc_n;
      if (load) begin
        out_valid   <= 1'b1;
        out_inst    <= sel_inst;
        out_pc      <= buf_pc;
        out_is_c    <= head_c;
        out_illegal <= head_c && x_ill;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

  // Immediate format is picked from opcode bits of the expanded word.
  always_comb begin
    if (out_inst[3])
      out_imm = {{12{out_inst[31]}}, out_inst[19:12], out_inst[20], out_inst[30:21], 1'b0};
    else if (!out_inst[5] || out_inst[2])
      out_imm = {{20{out_inst[31]}}, out_inst[31:20]};
    else if (out_inst[6])
      out_imm = {{20{out_inst[31]}}, out_inst[7], out_inst[30:25], out_inst[11:8], 1'b0};
    else
      out_imm = {{21{out_inst[31]}}, out_inst[30:25], out_inst[11:7]};
  end

  assign out_rs1 = out_inst[19:15];
  assign out_rs2 = out_inst[24:20];
  assign out_rd  = out_inst[11:7];
endmodule

// File: tb/tb_rvc_fetch_decoder.sv
// Directed bench for rvc_fetch_decoder: realignment, expansion, illegal handling, stall, reset and flush.
module tb_rvc_fetch_decoder;
  logic        clk = 1'b0;
  logic        rst, flush, in_valid, in_ready, out_valid, out_ready, out_is_c, out_illegal;
  logic [31:0] in_data, in_pc, out_inst, out_pc, out_imm;
  logic [4:0]  out_rs1, out_rs2, out_rd;
  int          total = 0;
  int          bad = 0;

  typedef struct {
    logic [31:0] pc, inst, imm;
    logic        isc, ill;
    logic [4:0]  rs1, rs2, rd;
  } rec_t;
  rec_t q[$];
  rec_t mon_r;

  rvc_fetch_decoder #(.EN_RVC(1'b1), .BUF_HW(4), .PC_W(32)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_pc(in_pc),
    .out_valid(out_valid), .out_ready(out_ready), .out_inst(out_inst), .out_pc(out_pc),
    .out_is_c(out_is_c), .out_illegal(out_illegal), .out_imm(out_imm),
    .out_rs1(out_rs1), .out_rs2(out_rs2), .out_rd(out_rd)
  );

  always #5 clk = ~clk;

  // Record every output handshake that will complete at the next rising edge.
  always @(negedge clk) begin
    if (!rst && !flush && out_valid && out_ready) begin
      mon_r.pc = out_pc; mon_r.inst = out_inst; mon_r.imm = out_imm;
      mon_r.isc = out_is_c; mon_r.ill = out_illegal;
      mon_r.rs1 = out_rs1; mon_r.rs2 = out_rs2; mon_r.rd = out_rd;
      q.push_back(mon_r);
    end
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Called just after a rising edge; returns just after the edge that took the word.
  task automatic send_word(input logic [31:0] data, input logic [31:0] pc);
    logic ok;
    ok = 1'b0;
    in_valid = 1'b1; in_data = data; in_pc = pc;
    for (int n = 0; n < 100 && !ok; n++) begin
      @(negedge clk);
      ok = in_ready;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    if (!ok) chk("send.timeout", 0, 1);
  endtask

  task automatic expect_out(input string tag, input logic [31:0] pc, input logic [31:0] inst,
                            input logic isc, input logic ill, input logic [31:0] imm,
                            input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd);
    rec_t r;
    int   n;
    n = 0;
    while (q.size() == 0 && n < 100) begin @(posedge clk); n++; end
    if (n > 0) #1;
    if (q.size() == 0) begin chk({tag, ".timeout"}, 0, 1); return; end
    r = q.pop_front();
    chk({tag, ".pc"}, r.pc, pc);
    chk({tag, ".inst"}, r.inst, inst);
    chk({tag, ".isc_ill"}, {r.isc, r.ill}, {isc, ill});
    chk({tag, ".imm"}, r.imm, imm);
    chk({tag, ".regs"}, {r.rs1, r.rs2, r.rd}, {rs1, rs2, rd});
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_data = 32'h0; in_pc = 32'h0; out_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst.in_ready", in_ready, 0);
    chk("rst.out_valid", out_valid, 0);
    chk("rst.out_inst", out_inst, 0);
    chk("rst.out_pc", out_pc, 0);
    @(posedge clk); #1;
    rst = 1'b0;

    // c.li, straddling 32-bit addi, c.mv
    send_word(32'h0513_4515, 32'h0);
    send_word(32'h852E_0050, 32'h4);
    expect_out("t1a", 32'h0, 32'h0050_0513, 1, 0, 32'd5, 0, 5, 10);
    expect_out("t1b", 32'h2, 32'h0050_0513, 0, 0, 32'd5, 0, 5, 10);
    expect_out("t1c", 32'h6, 32'h00B0_0533, 1, 0, 32'd10, 0, 11, 10);

    // Redirect to an odd halfword: lower half must be dropped
    flush = 1'b1; @(posedge clk); #1; flush = 1'b0;
    send_word(32'h852E_FFFF, 32'h102);
    expect_out("t2", 32'h102, 32'h00B0_0533, 1, 0, 32'd10, 0, 11, 10);

    // All-zero halfword and c.lwsp are illegal
    send_word(32'h4502_0000, 32'h200);
    expect_out("t3a", 32'h200, 32'h0, 1, 1, 32'h0, 0, 0, 0);
    expect_out("t3b", 32'h202, 32'h0, 1, 1, 32'h0, 0, 0, 0);

    // c.beqz x8,-2 then c.nop
    send_word(32'h0001_DC7D, 32'h300);
    expect_out("t4a", 32'h300, 32'hFE04_0FE3, 1, 0, 32'hFFFF_FFFE, 8, 0, 31);
    expect_out("t4b", 32'h302, 32'h0000_0013, 1, 0, 32'h0, 0, 0, 0);

    // Downstream stall with a continuous fetch stream of c.li x10,k
    out_ready = 1'b0;
    fork
      begin
        for (int j = 0; j < 4; j++)
          send_word({16'h4501 | 16'((2*j+1) << 2), 16'h4501 | 16'((2*j) << 2)}, 32'h400 + 32'(4*j));
      end
      begin
        n = 0;
        while (!out_valid && n < 50) begin @(negedge clk); n++; end
        chk("stall.first_vld", out_valid, 1);
        repeat (5) begin
          chk("stall.vld", out_valid, 1);
          chk("stall.pc", out_pc, 32'h400);
          chk("stall.inst", out_inst, 32'h0000_0513);
          chk("stall.in_ready", in_ready, 0);
          @(negedge clk);
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
      end
    join
    for (int k = 0; k < 8; k++)
      expect_out($sformatf("stall%0d", k), 32'h400 + 32'(2*k), (32'(k) << 20) | 32'h513,
                 1, 0, 32'(k), 0, 5'(k), 10);
    repeat (5) @(posedge clk); #1;
    chk("stall.no_extra", q.size(), 0);

    // Reset while an output is pending
    out_ready = 1'b0;
    send_word(32'h0001_0001, 32'h500);
    n = 0;
    while (!out_valid && n < 50) begin @(negedge clk); n++; end
    chk("rstmid.vld_before", out_valid, 1);
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    chk("rstmid.in_ready", in_ready, 0);
    @(negedge clk);
    chk("rstmid.out_valid", out_valid, 0);
    chk("rstmid.out_inst", out_inst, 0);
    chk("rstmid.out_pc", out_pc, 0);
    @(posedge clk); #1;
    rst = 1'b0; out_ready = 1'b1;
    repeat (4) @(negedge clk);
    chk("rstmid.empty_vld", out_valid, 0);
    chk("rstmid.empty_q", q.size(), 0);
    @(posedge clk); #1;

    // Flush together with in_valid: the word must not be taken
    flush = 1'b1; in_valid = 1'b1; in_data = 32'h0001_0001; in_pc = 32'h600;
    @(negedge clk);
    chk("flush.in_ready", in_ready, 0);
    @(posedge clk); #1;
    flush = 1'b0; in_valid = 1'b0;
    repeat (4) @(negedge clk);
    chk("flush.out_valid", out_valid, 0);
    chk("flush.q", q.size(), 0);
    @(posedge clk); #1;
    send_word(32'h0001_4515, 32'h700);
    expect_out("t7a", 32'h700, 32'h0050_0513, 1, 0, 32'd5, 0, 5, 10);
    expect_out("t7b", 32'h702, 32'h0000_0013, 1, 0, 32'h0, 0, 0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
